// File: rtl/rvfi_retire_pkg.sv
// Shared types and helpers for the multi-retire RVFI capture buffer.
package rvfi_retire_pkg;

   localparam int unsigned ORDER_W_DEFAULT = 64;
   localparam int unsigned XLEN_DEFAULT    = 32;
   localparam int unsigned REC_ORDER_W     = ORDER_W_DEFAULT;
   localparam int unsigned REC_XLEN        = XLEN_DEFAULT;
   localparam int unsigned INSN_W          = 32;
   localparam int unsigned REG_W           = 5;
   localparam int unsigned MAX_NRET        = 4;
   localparam int unsigned CNT_W           = 3;

   typedef struct packed {
      logic [REC_ORDER_W-1:0] order;
      logic [INSN_W-1:0]      insn;
      logic                   trap;
      logic [REC_XLEN-1:0]    pc_rdata;
      logic [REC_XLEN-1:0]    pc_wdata;
      logic [REG_W-1:0]       rd_addr;
      logic [REC_XLEN-1:0]    rd_wdata;
   } rec_t;

   localparam int unsigned REC_W = $bits(rec_t);

   // Number of set lane-valid bits; callers zero-extend to MAX_NRET.
   function automatic logic [CNT_W-1:0] popcount_lanes(input logic [MAX_NRET-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(MAX_NRET); i++) begin
         c = c + CNT_W'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/rvfi_retire_compact.sv
// Combinational lane compactor: packs valid lanes, in lane order, into the low slots.
module rvfi_retire_compact
   import rvfi_retire_pkg::*;
#(
   parameter int unsigned NRET = 2
) (
   input  logic                  lane_valid [NRET],
   input  rec_t                  lane_rec   [NRET],
   output logic [CNT_W-1:0]      k,
   output rec_t                  slot_rec   [NRET],
   output logic [NRET-1:0]       slot_we
);

   localparam int unsigned SLOT_W = (NRET > 1) ? $clog2(NRET) : 1;

   logic [MAX_NRET-1:0] valid_vec;
   logic [SLOT_W-1:0]   idx;

   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < int'(NRET); i++) begin
         valid_vec[i] = lane_valid[i];
      end
   end

   // Slot index only advances on a valid lane, so invalid lanes leave no holes.
   always_comb begin
      k       = popcount_lanes(valid_vec);
      slot_we = '0;
      idx     = '0;
      for (int s = 0; s < int'(NRET); s++) begin
         slot_rec[s] = '0;
      end
      for (int i = 0; i < int'(NRET); i++) begin
         if (lane_valid[i]) begin
            slot_rec[idx] = lane_rec[i];
            slot_we[idx]  = 1'b1;
            idx           = idx + SLOT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rvfi_retire_fifo.sv
// Multi-retire RVFI capture FIFO with all-or-nothing admission, drop counting
// and retirement order continuity checking.
module rvfi_retire_fifo
   import rvfi_retire_pkg::*;
#(
   parameter int unsigned NRET    = 2,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned XLEN    = XLEN_DEFAULT,
   parameter int unsigned ORDER_W = ORDER_W_DEFAULT,
   parameter int unsigned DROP_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NRET-1:0]           in_valid,
   input  logic [NRET*ORDER_W-1:0]   in_order,
   input  logic [NRET*32-1:0]        in_insn,
   input  logic [NRET-1:0]           in_trap,
   input  logic [NRET*XLEN-1:0]      in_pc_rdata,
   input  logic [NRET*XLEN-1:0]      in_pc_wdata,
   input  logic [NRET*5-1:0]         in_rd_addr,
   input  logic [NRET*XLEN-1:0]      in_rd_wdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [REC_W-1:0]          out_rec,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   output logic                      order_err,
   output logic [DROP_W-1:0]         drop_cnt
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam int unsigned DSUM_W = DROP_W + 1;

   rec_t               mem [DEPTH];
   rec_t               lane_rec [NRET];
   logic               lane_valid [NRET];
   rec_t               slot_rec [NRET];
   logic [NRET-1:0]    slot_we;
   logic [CNT_W-1:0]   k;

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   free;
   logic [LVL_W-1:0]   level_next;
   logic               accept;
   logic               drop;
   logic               pop;
   logic [DSUM_W-1:0]  drop_sum;

   logic [ORDER_W-1:0] exp_order;
   logic               exp_vld;
   logic [ORDER_W-1:0] exp_order_next;
   logic               exp_vld_next;
   logic               order_err_next;

   // Unflatten the probed per-lane RVFI buses into records.
   always_comb begin
      for (int i = 0; i < int'(NRET); i++) begin
         lane_valid[i]        = in_valid[i];
         lane_rec[i].order    = REC_ORDER_W'(in_order[i*ORDER_W +: ORDER_W]);
         lane_rec[i].insn     = in_insn[i*32 +: 32];
         lane_rec[i].trap     = in_trap[i];
         lane_rec[i].pc_rdata = REC_XLEN'(in_pc_rdata[i*XLEN +: XLEN]);
         lane_rec[i].pc_wdata = REC_XLEN'(in_pc_wdata[i*XLEN +: XLEN]);
         lane_rec[i].rd_addr  = in_rd_addr[i*5 +: 5];
         lane_rec[i].rd_wdata = REC_XLEN'(in_rd_wdata[i*XLEN +: XLEN]);
      end
   end

   rvfi_retire_compact #(
      .NRET (NRET)
   ) u_compact (
      .lane_valid (lane_valid),
      .lane_rec   (lane_rec),
      .k          (k),
      .slot_rec   (slot_rec),
      .slot_we    (slot_we)
   );

   // Admission sees only the registered level; a same-cycle pop gives no credit.
   assign free       = LVL_W'(DEPTH) - level;
   assign accept     = (LVL_W'(k) <= free);
   assign drop       = (k != '0) && !accept;
   assign pop        = out_valid && out_ready;
   assign level_next = level + (accept ? LVL_W'(k) : LVL_W'(0)) - LVL_W'(pop);
   assign drop_sum   = {1'b0, drop_cnt} + DSUM_W'(k);
   assign out_rec    = mem[rd_ptr];

   // Order continuity: every valid lane, accepted or dropped, resyncs the expectation.
   always_comb begin
      exp_order_next = exp_order;
      exp_vld_next   = exp_vld;
      order_err_next = order_err;
      for (int i = 0; i < int'(NRET); i++) begin
         if (in_valid[i]) begin
            if (exp_vld_next && (ORDER_W'(lane_rec[i].order) != exp_order_next)) begin
               order_err_next = 1'b1;
            end
            exp_order_next = ORDER_W'(lane_rec[i].order) + ORDER_W'(1);
            exp_vld_next   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (accept) begin
         for (int s = 0; s < int'(NRET); s++) begin
            if (slot_we[s]) begin
               mem[wr_ptr + PTR_W'(s)] <= slot_rec[s];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
         exp_order <= '0;
         exp_vld   <= 1'b0;
         order_err <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(k);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level     <= level_next;
         out_valid <= (level_next != '0);
         if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
         end
         exp_order <= exp_order_next;
         exp_vld   <= exp_vld_next;
         order_err <= order_err_next;
      end
   end

endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// Directed self-checking bench for rvfi_retire_fifo (NRET=2, DEPTH=8).
module tb_rvfi_retire_fifo;
   import rvfi_retire_pkg::*;

   localparam int unsigned NRET = 2;
   localparam int unsigned DEPTH = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        in_valid = '0;
   logic [127:0]      in_order = '0;
   logic [63:0]       in_insn = '0;
   logic [1:0]        in_trap = '0;
   logic [63:0]       in_pc_rdata = '0;
   logic [63:0]       in_pc_wdata = '0;
   logic [9:0]        in_rd_addr = '0;
   logic [63:0]       in_rd_wdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [REC_W-1:0]  out_rec;
   logic [3:0]        level;
   logic              overflow;
   logic              order_err;
   logic [15:0]       drop_cnt;
   rec_t              head;

   int checks = 0;
   int failures = 0;

   assign head = rec_t'(out_rec);

   always #5 clk = ~clk;

   rvfi_retire_fifo #(
      .NRET(NRET), .DEPTH(DEPTH), .XLEN(32), .ORDER_W(64), .DROP_W(16)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn), .in_trap(in_trap),
      .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata),
      .in_rd_addr(in_rd_addr), .in_rd_wdata(in_rd_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
      .level(level), .overflow(overflow), .order_err(order_err), .drop_cnt(drop_cnt)
   );

   function automatic logic [31:0] insn_of(input logic [63:0] o);
      return o[31:0] ^ 32'h1357_9BDF;
   endfunction
   function automatic logic [31:0] pc_of(input logic [63:0] o);
      return 32'h8000_0000 + (o[31:0] << 2);
   endfunction

   // Drive one cycle of stimulus from a negedge; returns at the next negedge.
   task automatic cyc(input logic [1:0] m, input logic [63:0] o0, input logic [63:0] o1,
                      input logic rdy);
      in_valid    = m;
      in_order    = {o1, o0};
      in_insn     = {insn_of(o1), insn_of(o0)};
      in_trap     = {o1[3], o0[3]};
      in_pc_rdata = {pc_of(o1), pc_of(o0)};
      in_pc_wdata = {pc_of(o1) + 32'd4, pc_of(o0) + 32'd4};
      in_rd_addr  = {o1[4:0], o0[4:0]};
      in_rd_wdata = {~o1[31:0], ~o0[31:0]};
      out_ready   = rdy;
      @(negedge clk);
      in_valid  = '0;
      out_ready = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      in_valid = '0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
      checks++; if (overflow !== 1'b0 || order_err !== 1'b0) begin failures++; $display("FAIL reset_flags got ovf=%0b oerr=%0b exp=0,0", overflow, order_err); end
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
      checks++; if (out_rec !== '0) begin failures++; $display("FAIL reset_out_rec got=%h exp=0", out_rec); end
   endtask

   task automatic test_basic();
      apply_reset();
      cyc(2'b11, 64'd10, 64'd11, 1'b1);
      checks++; if (out_valid !== 1'b1 || head.order !== 64'd10) begin failures++; $display("FAIL basic_first got v=%0b order=%0d exp v=1 order=10", out_valid, head.order); end
      checks++; if (level !== 4'd2) begin failures++; $display("FAIL basic_level2 got=%0d exp=2", level); end
      cyc(2'b00, 64'd0, 64'd0, 1'b1);
      checks++; if (head.order !== 64'd11 || level !== 4'd1) begin failures++; $display("FAIL basic_second got order=%0d level=%0d exp order=11 level=1", head.order, level); end
      checks++; if (head.insn !== insn_of(64'd11) || head.pc_rdata !== pc_of(64'd11) || head.pc_wdata !== pc_of(64'd11) + 32'd4) begin failures++; $display("FAIL basic_fields got insn=%h pc=%h npc=%h exp insn=%h pc=%h", head.insn, head.pc_rdata, head.pc_wdata, insn_of(64'd11), pc_of(64'd11)); end
      checks++; if (head.rd_addr !== 5'd11 || head.rd_wdata !== ~32'd11 || head.trap !== 1'b1) begin failures++; $display("FAIL basic_rd got rd=%0d wd=%h trap=%0b exp rd=11 wd=%h trap=1", head.rd_addr, head.rd_wdata, head.trap, ~32'd11); end
      cyc(2'b00, 64'd0, 64'd0, 1'b1);
      checks++; if (level !== 4'd0 || out_valid !== 1'b0 || order_err !== 1'b0) begin failures++; $display("FAIL basic_drain got level=%0d v=%0b oerr=%0b exp 0,0,0", level, out_valid, order_err); end
   endtask

   task automatic test_compact();
      apply_reset();
      cyc(2'b10, 64'd99, 64'd5, 1'b0);
      cyc(2'b01, 64'd6, 64'd77, 1'b0);
      checks++; if (level !== 4'd2 || head.order !== 64'd5) begin failures++; $display("FAIL compact_head got level=%0d order=%0d exp level=2 order=5", level, head.order); end
      cyc(2'b00, 64'd0, 64'd0, 1'b1);
      checks++; if (head.order !== 64'd6 || level !== 4'd1) begin failures++; $display("FAIL compact_next got order=%0d level=%0d exp order=6 level=1", head.order, level); end
      checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL compact_order_err got=%0b exp=0", order_err); end
      cyc(2'b00, 64'd0, 64'd0, 1'b1);
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(2'b11, 64'(2*i), 64'(2*i+1), 1'b0);
      end
      checks++; if (level !== 4'd8 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got level=%0d ovf=%0b exp level=8 ovf=0", level, overflow); end
      cyc(2'b11, 64'd8, 64'd9, 1'b0);
      checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd2 || level !== 4'd8) begin failures++; $display("FAIL ovf_drop got ovf=%0b drop=%0d level=%0d exp 1,2,8", overflow, drop_cnt, level); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (out_valid !== 1'b1 || head.order !== 64'(i)) begin failures++; $display("FAIL ovf_drain_%0d got v=%0b order=%0d exp v=1 order=%0d", i, out_valid, head.order, i); end
         cyc(2'b00, 64'd0, 64'd0, 1'b1);
      end
      checks++; if (level !== 4'd0 || out_valid !== 1'b0 || order_err !== 1'b0) begin failures++; $display("FAIL ovf_empty got level=%0d v=%0b oerr=%0b exp 0,0,0", level, out_valid, order_err); end
   endtask

   task automatic test_order();
      apply_reset();
      cyc(2'b01, 64'd20, 64'd0, 1'b1);
      checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL order_first got=%0b exp=0", order_err); end
      cyc(2'b01, 64'd22, 64'd0, 1'b1);
      checks++; if (order_err !== 1'b1) begin failures++; $display("FAIL order_gap got=%0b exp=1", order_err); end
      cyc(2'b01, 64'd23, 64'd0, 1'b1);
      checks++; if (order_err !== 1'b1) begin failures++; $display("FAIL order_sticky got=%0b exp=1", order_err); end
      cyc(2'b00, 64'd0, 64'd0, 1'b1);
      apply_reset();
      cyc(2'b11, 64'd40, 64'd41, 1'b1);
      checks++; if (order_err !== 1'b0) begin failures++; $display("FAIL order_lane_ok got=%0b exp=0", order_err); end
      cyc(2'b11, 64'd42, 64'd44, 1'b1);
      checks++; if (order_err !== 1'b1) begin failures++; $display("FAIL order_intra_cycle got=%0b exp=1", order_err); end
   endtask

   task automatic test_simul();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(2'b11, 64'(2*i), 64'(2*i+1), 1'b0);
      end
      cyc(2'b01, 64'd6, 64'd0, 1'b0);
      checks++; if (level !== 4'd7) begin failures++; $display("FAIL simul_level7 got=%0d exp=7", level); end
      cyc(2'b01, 64'd7, 64'd0, 1'b1);
      checks++; if (level !== 4'd7 || overflow !== 1'b0 || head.order !== 64'd1) begin failures++; $display("FAIL simul_k1 got level=%0d ovf=%0b order=%0d exp 7,0,1", level, overflow, head.order); end
      cyc(2'b11, 64'd8, 64'd9, 1'b1);
      checks++; if (level !== 4'd6 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin failures++; $display("FAIL simul_k2 got level=%0d ovf=%0b drop=%0d exp 6,1,2", level, overflow, drop_cnt); end
      checks++; if (head.order !== 64'd2 || order_err !== 1'b0) begin failures++; $display("FAIL simul_head got order=%0d oerr=%0b exp 2,0", head.order, order_err); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      cyc(2'b11, 64'd0, 64'd1, 1'b0);
      cyc(2'b11, 64'd2, 64'd3, 1'b0);
      cyc(2'b01, 64'd4, 64'd0, 1'b0);
      cyc(2'b11, 64'd9, 64'd10, 1'b0);
      checks++; if (level !== 4'd7 || order_err !== 1'b1) begin failures++; $display("FAIL mid_pre got level=%0d oerr=%0b exp 7,1", level, order_err); end
      reset = 1'b1;
      #2;
      checks++; if (out_valid !== 1'b0 || level !== 4'd0 || out_rec !== '0) begin failures++; $display("FAIL mid_async got v=%0b level=%0d rec=%h exp all 0", out_valid, level, out_rec); end
      checks++; if (overflow !== 1'b0 || order_err !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL mid_flags got ovf=%0b oerr=%0b drop=%0d exp 0,0,0", overflow, order_err, drop_cnt); end
      @(negedge clk);
      reset = 1'b0;
      cyc(2'b01, 64'd100, 64'd0, 1'b0);
      checks++; if (level !== 4'd1 || head.order !== 64'd100 || order_err !== 1'b0) begin failures++; $display("FAIL mid_after got level=%0d order=%0d oerr=%0b exp 1,100,0", level, head.order, order_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_compact();
      test_overflow();
      test_order();
      test_simul();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
